seg7_scan4: RTL

Downstream consumer of the 14-bit-to-BCD converter: captures the four BCD digits when the converter pulses `done`, then drives the board's 4-digit common-anode 7-segment display by time-multiplexing. Provides leading-zero blanking, invalid-digit indication, anti-ghosting dead time and tear-free updates applied only at frame boundaries. Sits between the BCD converter and the display pins at the top level.

---
 rtl/seg7_scan4.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment driver with leading-zero blanking and
// frame-synchronous display updates from a pending capture buffer.
module seg7_scan4 #(
    parameter int PRESCALE = 2000,
    parameter int BLANK    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] dp_sel,
    input  logic       lz_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] CNT_ON   = 16'(BLANK);

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [3:0]  r_pa, r_pb, r_pc, r_pd, r_pdp;
    logic        r_pend_v;
    logic [3:0]  r_da, r_db, r_dc, r_dd, r_ddp;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        r_frame;

    logic        w_wrap;
    logic        w_bnd;
    logic        w_on;
    logic [3:0]  w_dig;
    logic        w_blank;
    logic        w_dpsel;
    logic [3:0]  w_an_sel;
    logic [6:0]  w_dec;
    logic [6:0]  w_seg_nxt;
    logic [3:0]  w_an_nxt;
    logic        w_dp_nxt;

    assign w_wrap = (r_cnt == CNT_LAST);
    assign w_bnd  = w_wrap && (r_idx == 2'd3);
    assign w_on   = (r_cnt >= CNT_ON);

    // Slot 0 is the leftmost digit; blanking depends on all digits to its left.
    always_comb begin
        w_dig    = r_da;
        w_blank  = 1'b0;
        w_dpsel  = r_ddp[3];
        w_an_sel = 4'b0111;
        unique case (r_idx)
            2'd0: begin
                w_dig    = r_da;
                w_blank  = lz_en && (r_da == 4'd0);
                w_dpsel  = r_ddp[3];
                w_an_sel = 4'b0111;
            end
            2'd1: begin
                w_dig    = r_db;
                w_blank  = lz_en && (r_da == 4'd0) && (r_db == 4'd0);
                w_dpsel  = r_ddp[2];
                w_an_sel = 4'b1011;
            end
            2'd2: begin
                w_dig    = r_dc;
                w_blank  = lz_en && (r_da == 4'd0) && (r_db == 4'd0)
                           && (r_dc == 4'd0);
                w_dpsel  = r_ddp[1];
                w_an_sel = 4'b1101;
            end
            default: begin
                w_dig    = r_dd;
                w_blank  = 1'b0;
                w_dpsel  = r_ddp[0];
                w_an_sel = 4'b1110;
            end
        endcase
    end

    always_comb begin
        w_dec = 7'b0111111;
        unique case (w_dig)
            4'd0:    w_dec = 7'b1000000;
            4'd1:    w_dec = 7'b1111001;
            4'd2:    w_dec = 7'b0100100;
            4'd3:    w_dec = 7'b0110000;
            4'd4:    w_dec = 7'b0011001;
            4'd5:    w_dec = 7'b0010010;
            4'd6:    w_dec = 7'b0000010;
            4'd7:    w_dec = 7'b1111000;
            4'd8:    w_dec = 7'b0000000;
            4'd9:    w_dec = 7'b0010000;
            default: w_dec = 7'b0111111;
        endcase
    end

    assign w_seg_nxt = w_blank ? 7'b1111111 : w_dec;
    assign w_an_nxt  = w_on ? w_an_sel : 4'b1111;
    assign w_dp_nxt  = w_on ? ~w_dpsel : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 16'd0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= 16'd0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Boundary transfer happens first; a coincident load refills pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pa     <= 4'd0;
            r_pb     <= 4'd0;
            r_pc     <= 4'd0;
            r_pd     <= 4'd0;
            r_pdp    <= 4'd0;
            r_pend_v <= 1'b0;
            r_da     <= 4'd0;
            r_db     <= 4'd0;
            r_dc     <= 4'd0;
            r_dd     <= 4'd0;
            r_ddp    <= 4'd0;
        end else begin
            if (w_bnd && r_pend_v) begin
                r_da     <= r_pa;
                r_db     <= r_pb;
                r_dc     <= r_pc;
                r_dd     <= r_pd;
                r_ddp    <= r_pdp;
                r_pend_v <= 1'b0;
            end
            if (load) begin
                r_pa     <= A;
                r_pb     <= B;
                r_pc     <= C;
                r_pd     <= D;
                r_pdp    <= dp_sel;
                r_pend_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an    <= 4'b1111;
            r_seg   <= 7'b1111111;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_frame <= (r_cnt == 16'd0) && (r_idx == 2'd0);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign frame = r_frame;

endmodule
